// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  seg7_pkg
//  Shared constants, frame type and hex-to-segment lookup for seg7_scan_driver.
//  Rev 1.0
// ============================================================================
package seg7_pkg;

   localparam int NUM_DIGITS_DEF = 8;

   // Segment order {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] HEX7_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef struct packed {
      logic [4*NUM_DIGITS_DEF-1:0] data;
      logic [NUM_DIGITS_DEF-1:0]   dp;
      logic                        lzb;
   } frame_t;

   function automatic logic [6:0] hex7(input logic [3:0] nibble);
      return HEX7_TABLE[nibble];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  seg7_scan_driver_if
//  Display-register inputs and scan outputs of the seven-segment driver.
//  Rev 1.0
// ============================================================================
interface seg7_scan_driver_if;
   import seg7_pkg::*;

   logic [4*NUM_DIGITS_DEF-1:0] SegData;
   logic [NUM_DIGITS_DEF-1:0]   DpMask;
   logic                        LzbEn;
   logic                        Enable;
   logic [NUM_DIGITS_DEF-1:0]   DigitSel;
   logic [7:0]                  SegOut;

   modport master (
      output SegData, DpMask, LzbEn, Enable,
      input  DigitSel, SegOut
   );

   modport slave (
      input  SegData, DpMask, LzbEn, Enable,
      output DigitSel, SegOut
   );

endinterface
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
//  seg7_hex_decoder
//  Combinational hex nibble to seven-segment pattern decoder.
//  Rev 1.0
// ============================================================================
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   always_comb segs = hex7(nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  seg7_scan_driver
//  Time-multiplexed 8-digit seven-segment driver with per-frame data latching.
//  Rev 1.0
// ============================================================================
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
)(
   input  logic              clk,
   input  logic              reset,
   seg7_scan_driver_if.slave bus
);

   localparam int                IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   if (REFRESH_DIV < 2 || (64'd1 << CNT_W) < 64'(REFRESH_DIV) ||
       NUM_DIGITS != NUM_DIGITS_DEF) begin : g_param_check
      $error("seg7_scan_driver: illegal NUM_DIGITS/REFRESH_DIV/CNT_W combination");
   end

   logic [CNT_W-1:0]      div_cnt;
   logic [IDX_W-1:0]      idx;
   frame_t                shadow;
   logic                  load_pending;
   logic [NUM_DIGITS-1:0] digit_sel;
   logic [7:0]            seg_out;

   logic                  tick;
   frame_t                live;
   frame_t                cur;
   logic [NUM_DIGITS-1:0] blank;
   logic [3:0]            nibble;
   logic [6:0]            segs;

   assign tick = (div_cnt == DIV_LAST);

   always_comb begin
      live.data = bus.SegData;
      live.dp   = bus.DpMask;
      live.lzb  = bus.LzbEn;
   end

   // The load cycle after reset shows the incoming frame directly, so digit 0
   // never flashes the cleared shadow.
   assign cur = load_pending ? live : shadow;

   assign blank[0] = 1'b0;
   for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_blank
      assign blank[i] = cur.lzb && (cur.data[4*NUM_DIGITS-1:4*i] == '0);
   end

   assign nibble = cur.data[{idx, 2'b00} +: 4];

   seg7_hex_decoder u_hex_decoder (
      .nibble (nibble),
      .segs   (segs)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt      <= '0;
         idx          <= '0;
         shadow       <= '0;
         load_pending <= 1'b1;
         digit_sel    <= '0;
         seg_out      <= '0;
      end else begin
         div_cnt      <= tick ? '0 : div_cnt + 1'b1;
         load_pending <= 1'b0;
         if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
         if (load_pending || (tick && idx == IDX_LAST)) begin
            shadow <= live;
         end
         if (bus.Enable && !blank[idx]) begin
            digit_sel <= NUM_DIGITS'(1) << idx;
            seg_out   <= {cur.dp[idx], segs};
         end else begin
            digit_sel <= '0;
            seg_out   <= '0;
         end
      end
   end

   assign bus.DigitSel = digit_sel;
   assign bus.SegOut   = seg_out;

endmodule
`default_nettype wire
